// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared opcode constants and sequencing state type
//
// Purpose: definitions shared by the pipeline sequencing control logic.
//   OP_LW / OP_LM / OP_SM : 4-bit opcodes the RR/EX sequencing cares about.
//   state_e               : LM/SM expansion state (idle or sequencing beats).
package pipe_ctrl_pkg;

  localparam logic [3:0] OP_LW = 4'b0100;
  localparam logic [3:0] OP_LM = 4'b0110;
  localparam logic [3:0] OP_SM = 4'b0111;

  typedef enum logic {
    ST_IDLE,
    ST_SEQ
  } state_e;

endpackage

// File: rtl/lsb_pick.sv
// rtl/lsb_pick.sv - lowest-set-bit index and one-hot select of a vector
//
// Purpose: combinational priority pick of the lowest set bit.
// Ports:
//   vec_i    : input vector to scan.
//   idx_o    : index of the lowest set bit (0 when vec_i is zero).
//   onehot_o : one-hot mask of that bit (zero when vec_i is zero); the caller
//              clears it with vec & ~onehot_o.
module lsb_pick #(
  parameter int W  = 8,
  parameter int IW = 3
) (
  input  logic [W-1:0]  vec_i,
  output logic [IW-1:0] idx_o,
  output logic [W-1:0]  onehot_o
);

  // Scan from the top down so the last hit, the lowest bit, wins.
  always_comb begin
    idx_o    = '0;
    onehot_o = '0;
    for (int i = W - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o       = IW'(i);
        onehot_o    = '0;
        onehot_o[i] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_stage_ctrl.sv
// rtl/rr_stage_ctrl.sv - RR/EX boundary sequencing: hazards, flushes, LM/SM expansion
//
// Purpose: drives front-end write enables, younger-stage flushes and the RR/EX
// valid bit. Inserts a one-cycle bubble on a load-use hazard, flushes on an EX
// redirect, and expands LM/SM into one micro-op per set mask bit while holding
// the front end.
// Optional feature macro: RR_STAGE_CTRL_PERF_CNT_EN enables saturating stall and
// flush counters; without it stall_cnt / flush_cnt are constant zero.
// Ports:
//   clock, reset              : clock, asynchronous active-high reset.
//   rr_valid, rr_opcode       : RR instruction valid and opcode.
//   rr_rs, rr_rt, rr_uses_*   : RR source registers and their use flags.
//   rr_mask                   : LM/SM register mask.
//   ex_valid, ex_is_load,
//   ex_rd, ex_redirect        : EX instruction info and taken-redirect strobe.
//   pc_we, ifid_we, idrr_we   : front-end register enables.
//   ifid_flush, idrr_flush    : clear the younger stage valids.
//   rrex_valid_in             : valid written into RR/EX.
//   lmsm_active, lmsm_reg,
//   lmsm_offset               : current LM/SM micro-op register and word offset.
//   stall_cnt, flush_cnt      : performance counters.
module rr_stage_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW = 3,
  parameter int MASK_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rr_valid,
  input  logic [3:0]        rr_opcode,
  input  logic [REG_AW-1:0] rr_rs,
  input  logic [REG_AW-1:0] rr_rt,
  input  logic              rr_uses_rs,
  input  logic              rr_uses_rt,
  input  logic [MASK_W-1:0] rr_mask,
  input  logic              ex_valid,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_redirect,
  output logic              pc_we,
  output logic              ifid_we,
  output logic              idrr_we,
  output logic              ifid_flush,
  output logic              idrr_flush,
  output logic              rrex_valid_in,
  output logic              lmsm_active,
  output logic [REG_AW-1:0] lmsm_reg,
  output logic [REG_AW-1:0] lmsm_offset,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  state_e              state_q, state_d;
  logic [MASK_W-1:0]   mask_q, mask_d;
  logic [REG_AW-1:0]   offset_q, offset_d;

  logic [REG_AW-1:0]   rr_idx;
  logic [MASK_W-1:0]   rr_onehot;
  logic [MASK_W-1:0]   rr_rest;
  logic [REG_AW-1:0]   sq_idx;
  logic [MASK_W-1:0]   sq_onehot;
  logic [MASK_W-1:0]   sq_rest;
  logic                luse;
  logic                is_lmsm;

  lsb_pick #(.W(MASK_W), .IW(REG_AW)) u_pick_rr (
    .vec_i    (rr_mask),
    .idx_o    (rr_idx),
    .onehot_o (rr_onehot)
  );

  lsb_pick #(.W(MASK_W), .IW(REG_AW)) u_pick_sq (
    .vec_i    (mask_q),
    .idx_o    (sq_idx),
    .onehot_o (sq_onehot)
  );

  assign rr_rest = rr_mask & ~rr_onehot;
  assign sq_rest = mask_q & ~sq_onehot;
  assign is_lmsm = (rr_opcode == OP_LM) || (rr_opcode == OP_SM);
  assign luse    = ex_valid & ex_is_load & rr_valid &
                   ((rr_uses_rs & (rr_rs == ex_rd)) | (rr_uses_rt & (rr_rt == ex_rd)));

  always_comb begin
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    idrr_we       = 1'b1;
    ifid_flush    = 1'b0;
    idrr_flush    = 1'b0;
    rrex_valid_in = 1'b0;
    lmsm_active   = 1'b0;
    lmsm_reg      = '0;
    lmsm_offset   = '0;
    state_d       = state_q;
    mask_d        = mask_q;
    offset_d      = offset_q;

    if (reset) begin
      // Keep the front end flowing and flushed while held in reset.
      ifid_flush = 1'b1;
      idrr_flush = 1'b1;
      state_d    = ST_IDLE;
      mask_d     = '0;
      offset_d   = '0;
    end else if (ex_redirect) begin
      ifid_flush = 1'b1;
      idrr_flush = 1'b1;
      state_d    = ST_IDLE;
      mask_d     = '0;
      offset_d   = '0;
    end else if (state_q == ST_SEQ) begin
      rrex_valid_in = 1'b1;
      lmsm_active   = 1'b1;
      lmsm_reg      = sq_idx;
      lmsm_offset   = offset_q;
      mask_d        = sq_rest;
      offset_d      = offset_q + REG_AW'(1);
      if (sq_rest == '0) begin
        // Last beat: release the front end; offset restarts so it never wraps.
        state_d  = ST_IDLE;
        offset_d = '0;
      end else begin
        pc_we   = 1'b0;
        ifid_we = 1'b0;
        idrr_we = 1'b0;
      end
    end else if (luse) begin
      pc_we   = 1'b0;
      ifid_we = 1'b0;
      idrr_we = 1'b0;
    end else if (rr_valid && is_lmsm) begin
      // An empty mask retires as a NOP: nothing enters RR/EX.
      if (rr_mask != '0) begin
        rrex_valid_in = 1'b1;
        lmsm_active   = 1'b1;
        lmsm_reg      = rr_idx;
        if (rr_rest != '0) begin
          pc_we    = 1'b0;
          ifid_we  = 1'b0;
          idrr_we  = 1'b0;
          mask_d   = rr_rest;
          offset_d = REG_AW'(1);
          state_d  = ST_SEQ;
        end
      end
    end else begin
      rrex_valid_in = rr_valid;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mask_q   <= '0;
      offset_q <= '0;
    end else begin
      state_q  <= state_d;
      mask_q   <= mask_d;
      offset_q <= offset_d;
    end
  end

`ifdef RR_STAGE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_we && (stall_q != '1)) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (ex_redirect && (flush_q != '1)) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_rr_stage_ctrl.sv
// tb/tb_rr_stage_ctrl.sv - self-checking bench for rr_stage_ctrl
module tb_rr_stage_ctrl;

  localparam int REG_AW = 3;
  localparam int MASK_W = 8;
  localparam int CNT_W  = 16;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              rr_valid = 1'b0;
  logic [3:0]        rr_opcode = '0;
  logic [REG_AW-1:0] rr_rs = '0;
  logic [REG_AW-1:0] rr_rt = '0;
  logic              rr_uses_rs = 1'b0;
  logic              rr_uses_rt = 1'b0;
  logic [MASK_W-1:0] rr_mask = '0;
  logic              ex_valid = 1'b0;
  logic              ex_is_load = 1'b0;
  logic [REG_AW-1:0] ex_rd = '0;
  logic              ex_redirect = 1'b0;
  logic              pc_we, ifid_we, idrr_we, ifid_flush, idrr_flush;
  logic              rrex_valid_in, lmsm_active;
  logic [REG_AW-1:0] lmsm_reg, lmsm_offset;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt;

  rr_stage_ctrl #(.REG_AW(REG_AW), .MASK_W(MASK_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .rr_valid(rr_valid), .rr_opcode(rr_opcode), .rr_rs(rr_rs), .rr_rt(rr_rt),
    .rr_uses_rs(rr_uses_rs), .rr_uses_rt(rr_uses_rt), .rr_mask(rr_mask),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .ex_redirect(ex_redirect),
    .pc_we(pc_we), .ifid_we(ifid_we), .idrr_we(idrr_we),
    .ifid_flush(ifid_flush), .idrr_flush(idrr_flush),
    .rrex_valid_in(rrex_valid_in), .lmsm_active(lmsm_active),
    .lmsm_reg(lmsm_reg), .lmsm_offset(lmsm_offset),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: pending LM/SM beats as a list of register numbers.
  int mq[$];
  int nq[$];
  int mbeat, nbeat;
  int m_stall, m_flush;
  logic e_we, e_flush, e_rrex, e_act;
  int e_reg, e_off;

  task automatic model_reset();
    mq.delete();
    nq.delete();
    mbeat = 0;
    nbeat = 0;
    m_stall = 0;
    m_flush = 0;
  endtask

  task automatic model_eval();
    bit hz;
    int bits[$];
    nq = mq;
    nbeat = mbeat;
    e_we = 1'b1; e_flush = 1'b0; e_rrex = 1'b0; e_act = 1'b0; e_reg = 0; e_off = 0;
    hz = ex_valid && ex_is_load && rr_valid &&
         ((rr_uses_rs && rr_rs == ex_rd) || (rr_uses_rt && rr_rt == ex_rd));
    if (ex_redirect) begin
      e_flush = 1'b1;
      nq.delete();
      nbeat = 0;
    end else if (mq.size() > 0) begin
      e_rrex = 1'b1; e_act = 1'b1; e_reg = mq[0]; e_off = mbeat;
      void'(nq.pop_front());
      nbeat = mbeat + 1;
      e_we = (nq.size() == 0);
    end else if (hz) begin
      e_we = 1'b0;
    end else if (rr_valid && (rr_opcode == 4'b0110 || rr_opcode == 4'b0111)) begin
      for (int i = 0; i < MASK_W; i++) if (rr_mask[i]) bits.push_back(i);
      if (bits.size() > 0) begin
        e_rrex = 1'b1; e_act = 1'b1; e_reg = bits[0]; e_off = 0;
        if (bits.size() > 1) begin
          e_we = 1'b0;
          void'(bits.pop_front());
          nq = bits;
          nbeat = 1;
        end
      end
    end else begin
      e_rrex = rr_valid;
    end
  endtask

  task automatic model_commit();
    mq = nq;
    mbeat = nbeat;
    if (!e_we && m_stall < (1 << CNT_W) - 1) m_stall++;
    if (ex_redirect && m_flush < (1 << CNT_W) - 1) m_flush++;
  endtask

  function automatic int exp_stall();
`ifdef RR_STAGE_CTRL_PERF_CNT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_flush();
`ifdef RR_STAGE_CTRL_PERF_CNT_EN
    return m_flush;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    rr_valid = 0; rr_opcode = 4'b0000; rr_rs = 0; rr_rt = 0; rr_uses_rs = 0; rr_uses_rt = 0;
    rr_mask = 0; ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_redirect = 0;
  endtask

  task automatic test_reset();
    // Enter SEQ with mask_q = 8'b1010_0000, then assert reset mid-cycle.
    idle_inputs();
    rr_valid = 1; rr_opcode = 4'b0110; rr_mask = 8'b1010_0001;
    #1; model_eval(); model_commit(); tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({pc_we, ifid_we, idrr_we, ifid_flush, idrr_flush} !== 5'b11111) begin
      errors++;
      $display("FAIL reset_we_flush: got %b expected 11111", {pc_we, ifid_we, idrr_we, ifid_flush, idrr_flush});
    end
    checks++;
    if ({rrex_valid_in, lmsm_active, lmsm_reg, lmsm_offset} !== 8'b0) begin
      errors++;
      $display("FAIL reset_issue: got rrex=%b act=%b reg=%0d off=%0d expected all 0",
               rrex_valid_in, lmsm_active, lmsm_reg, lmsm_offset);
    end
    tick();
    reset = 1'b0;
    model_reset();
    idle_inputs();
    #1;
    checks++;
    if (lmsm_active !== 1'b0 || rrex_valid_in !== 1'b0 || pc_we !== 1'b1 || ifid_flush !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_after: got act=%b rrex=%b pc_we=%b flush=%b expected 0 0 1 0",
               lmsm_active, rrex_valid_in, pc_we, ifid_flush);
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d expected 0 0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_load_use();
    idle_inputs();
    ex_valid = 1; ex_is_load = 1; ex_rd = 3;
    rr_valid = 1; rr_opcode = 4'b0000; rr_rs = 3; rr_uses_rs = 1; rr_rt = 5; rr_uses_rt = 1;
    #1; model_eval();
    checks++;
    if ({pc_we, ifid_we, idrr_we, rrex_valid_in} !== 4'b0000) begin
      errors++;
      $display("FAIL load_use_bubble: got we=%b%b%b rrex=%b expected 0000", pc_we, ifid_we, idrr_we, rrex_valid_in);
    end
    model_commit(); tick();
    ex_valid = 0; ex_is_load = 0;
    #1; model_eval();
    checks++;
    if ({pc_we, ifid_we, idrr_we, rrex_valid_in} !== 4'b1111) begin
      errors++;
      $display("FAIL load_use_release: got we=%b%b%b rrex=%b expected 1111", pc_we, ifid_we, idrr_we, rrex_valid_in);
    end
    model_commit(); tick();
    checks++;
    if (stall_cnt !== CNT_W'(exp_stall())) begin
      errors++;
      $display("FAIL load_use_stall_cnt: got %0d expected %0d", stall_cnt, exp_stall());
    end
  endtask

  task automatic test_lm_seq();
    int regs[3] = '{0, 2, 5};
    idle_inputs();
    rr_valid = 1; rr_opcode = 4'b0110; rr_mask = 8'b0010_0101;
    for (int b = 0; b < 3; b++) begin
      #1; model_eval();
      checks++;
      if (rrex_valid_in !== 1'b1 || lmsm_active !== 1'b1 || lmsm_reg !== REG_AW'(regs[b]) ||
          lmsm_offset !== REG_AW'(b) || pc_we !== (b == 2) || ifid_we !== (b == 2) || idrr_we !== (b == 2)) begin
        errors++;
        $display("FAIL lm_beat%0d: got rrex=%b act=%b reg=%0d off=%0d we=%b%b%b expected 1 1 %0d %0d we=%0d",
                 b, rrex_valid_in, lmsm_active, lmsm_reg, lmsm_offset, pc_we, ifid_we, idrr_we,
                 regs[b], b, (b == 2));
      end
      model_commit(); tick();
    end
    rr_valid = 0;
    #1; model_eval();
    checks++;
    if (lmsm_active !== 1'b0 || rrex_valid_in !== 1'b0) begin
      errors++;
      $display("FAIL lm_done: got act=%b rrex=%b expected 0 0", lmsm_active, rrex_valid_in);
    end
    model_commit(); tick();
  endtask

  task automatic test_sm_edge();
    idle_inputs();
    rr_valid = 1; rr_opcode = 4'b0111; rr_mask = 8'h00;
    #1; model_eval();
    checks++;
    if (rrex_valid_in !== 1'b0 || pc_we !== 1'b1 || lmsm_active !== 1'b0) begin
      errors++;
      $display("FAIL sm_empty: got rrex=%b pc_we=%b act=%b expected 0 1 0", rrex_valid_in, pc_we, lmsm_active);
    end
    model_commit(); tick();
    rr_mask = 8'h80;
    #1; model_eval();
    checks++;
    if (rrex_valid_in !== 1'b1 || lmsm_reg !== 3'd7 || lmsm_offset !== 3'd0 ||
        {pc_we, ifid_we, idrr_we} !== 3'b111 || lmsm_active !== 1'b1) begin
      errors++;
      $display("FAIL sm_single: got rrex=%b reg=%0d off=%0d we=%b%b%b act=%b expected 1 7 0 111 1",
               rrex_valid_in, lmsm_reg, lmsm_offset, pc_we, ifid_we, idrr_we, lmsm_active);
    end
    model_commit(); tick();
    rr_valid = 0;
    #1; model_eval();
    checks++;
    if (lmsm_active !== 1'b0) begin
      errors++;
      $display("FAIL sm_single_no_seq: got act=%b expected 0", lmsm_active);
    end
    model_commit(); tick();
  endtask

  task automatic test_redirect_mid_seq();
    idle_inputs();
    rr_valid = 1; rr_opcode = 4'b0110; rr_mask = 8'hFF;
    #1; model_eval(); model_commit(); tick();
    ex_redirect = 1;
    #1; model_eval();
    checks++;
    if ({ifid_flush, idrr_flush, pc_we, ifid_we, idrr_we} !== 5'b11111 || rrex_valid_in !== 1'b0) begin
      errors++;
      $display("FAIL redirect_flush: got flush=%b%b we=%b%b%b rrex=%b expected 11 111 0",
               ifid_flush, idrr_flush, pc_we, ifid_we, idrr_we, rrex_valid_in);
    end
    model_commit(); tick();
    ex_redirect = 0; rr_valid = 0;
    #1; model_eval();
    checks++;
    if (lmsm_active !== 1'b0 || rrex_valid_in !== 1'b0 || ifid_flush !== 1'b0) begin
      errors++;
      $display("FAIL redirect_abort: got act=%b rrex=%b flush=%b expected 0 0 0", lmsm_active, rrex_valid_in, ifid_flush);
    end
    model_commit(); tick();
  endtask

  task automatic test_redirect_vs_luse();
    idle_inputs();
    ex_valid = 1; ex_is_load = 1; ex_rd = 6; ex_redirect = 1;
    rr_valid = 1; rr_opcode = 4'b0001; rr_rt = 6; rr_uses_rt = 1;
    #1; model_eval();
    checks++;
    if (pc_we !== 1'b1 || ifid_flush !== 1'b1 || idrr_flush !== 1'b1 || rrex_valid_in !== 1'b0) begin
      errors++;
      $display("FAIL redirect_over_luse: got pc_we=%b flush=%b%b rrex=%b expected 1 11 0",
               pc_we, ifid_flush, idrr_flush, rrex_valid_in);
    end
    model_commit(); tick();
    checks++;
    if (flush_cnt !== CNT_W'(exp_flush()) || stall_cnt !== CNT_W'(exp_stall())) begin
      errors++;
      $display("FAIL redirect_counters: got flush=%0d stall=%0d expected %0d %0d",
               flush_cnt, stall_cnt, exp_flush(), exp_stall());
    end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      int sel;
      rr_valid   = ($urandom_range(0, 9) < 8);
      sel        = $urandom_range(0, 5);
      rr_opcode  = (sel == 0) ? 4'b0110 : (sel == 1) ? 4'b0111 : (sel == 2) ? 4'b0100 : 4'($urandom_range(0, 15));
      rr_rs      = 3'($urandom_range(0, 7));
      rr_rt      = 3'($urandom_range(0, 7));
      rr_uses_rs = 1'($urandom_range(0, 1));
      rr_uses_rt = 1'($urandom_range(0, 1));
      sel        = $urandom_range(0, 3);
      rr_mask    = (sel == 0) ? 8'h00 : (sel == 1) ? 8'(1 << $urandom_range(0, 7)) : 8'($urandom_range(0, 255));
      ex_valid   = 1'($urandom_range(0, 1));
      ex_is_load = 1'($urandom_range(0, 1));
      ex_rd      = 3'($urandom_range(0, 7));
      ex_redirect = ($urandom_range(0, 11) == 0);
      #1; model_eval();
      checks++;
      if (pc_we !== e_we || ifid_we !== e_we || idrr_we !== e_we || ifid_flush !== e_flush ||
          idrr_flush !== e_flush || rrex_valid_in !== e_rrex || lmsm_active !== e_act ||
          (e_act && (lmsm_reg !== REG_AW'(e_reg) || lmsm_offset !== REG_AW'(e_off)))) begin
        errors++;
        $display("FAIL random_cycle%0d: got we=%b%b%b fl=%b%b rrex=%b act=%b reg=%0d off=%0d expected we=%b fl=%b rrex=%b act=%b reg=%0d off=%0d",
                 n, pc_we, ifid_we, idrr_we, ifid_flush, idrr_flush, rrex_valid_in, lmsm_active,
                 lmsm_reg, lmsm_offset, e_we, e_flush, e_rrex, e_act, e_reg, e_off);
      end
      model_commit(); tick();
    end
    checks++;
    if (stall_cnt !== CNT_W'(exp_stall()) || flush_cnt !== CNT_W'(exp_flush())) begin
      errors++;
      $display("FAIL random_counters: got stall=%0d flush=%0d expected %0d %0d",
               stall_cnt, flush_cnt, exp_stall(), exp_flush());
    end
  endtask

  initial begin
    model_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    test_reset();
    test_load_use();
    test_lm_seq();
    test_sm_edge();
    test_redirect_mid_seq();
    test_redirect_vs_luse();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
